// File: rtl/ml_feature_extract.sv
// ml_feature_extract
//   Front-end feature stage for the driver-monitor scorer. Turns raw per-sample
//   telemetry into first/second-difference features with saturation, and
//   gates feat_valid behind a warm-up state machine and an inactivity timeout.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   sample_valid one-cycle strobe: speed/steer_angle/brake_in carry a new sample
//   speed        unsigned speed sample
//   steer_angle  signed steering angle sample
//   brake_in     unsigned brake pressure sample
//   accel        signed sat(speed[n] - speed[n-1])
//   jerk         signed sat(accel[n] - accel[n-1])
//   steer        signed sat(steer_angle[n] - steer_angle[n-1])
//   brake        brake_in[n] registered
//   feat_valid   one-cycle pulse: all four features updated and valid
//   warm         level: history full (RUN)
//   stale        level: timeout fired, cleared by next sample_valid
module ml_feature_extract #(
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic        [7:0]  speed,
    input  logic signed [7:0]  steer_angle,
    input  logic        [7:0]  brake_in,
    output logic signed [7:0]  accel,
    output logic signed [7:0]  jerk,
    output logic signed [7:0]  steer,
    output logic        [7:0]  brake,
    output logic               feat_valid,
    output logic               warm,
    output logic               stale
);

    localparam logic [15:0] TO_CNT  = 16'(TIMEOUT);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {EMPTY, ONE, TWO, RUN} state_t;

    state_t             state;
    logic        [15:0] idle_cnt;
    logic        [7:0]  prev_speed;
    logic signed [7:0]  prev_steer;
    logic signed [7:0]  prev_accel;

    logic signed [8:0]  dspeed;
    logic signed [8:0]  dsteer;
    logic signed [8:0]  daccel;
    logic signed [7:0]  accel_n;
    logic signed [7:0]  steer_n;
    logic signed [7:0]  jerk_n;

    function automatic logic signed [7:0] sat9(input logic signed [8:0] d);
        if (d > 9'sd127)
            return 8'sh7F;
        else if (d < -9'sd128)
            return 8'sh80;
        else
            return d[7:0];
    endfunction

    // Differences are formed at 9 bits so the full -255..255 range is exact
    // before clamping; jerk is taken from the clamped accel values.
    always_comb begin
        dspeed  = $signed({1'b0, speed}) - $signed({1'b0, prev_speed});
        dsteer  = $signed({steer_angle[7], steer_angle}) - $signed({prev_steer[7], prev_steer});
        accel_n = sat9(dspeed);
        steer_n = sat9(dsteer);
        daccel  = $signed({accel_n[7], accel_n}) - $signed({prev_accel[7], prev_accel});
        jerk_n  = sat9(daccel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            idle_cnt   <= '0;
            prev_speed <= '0;
            prev_steer <= '0;
            prev_accel <= '0;
            accel      <= '0;
            jerk       <= '0;
            steer      <= '0;
            brake      <= '0;
            feat_valid <= 1'b0;
            warm       <= 1'b0;
            stale      <= 1'b0;
        end else begin
            feat_valid <= 1'b0;
            if (sample_valid) begin
                // A sample always beats a timeout landing on the same edge.
                idle_cnt   <= '0;
                stale      <= 1'b0;
                prev_speed <= speed;
                prev_steer <= steer_angle;
                brake      <= brake_in;
                case (state)
                    EMPTY: begin
                        state <= ONE;
                    end
                    ONE: begin
                        accel      <= accel_n;
                        steer      <= steer_n;
                        jerk       <= '0;
                        prev_accel <= accel_n;
                        state      <= TWO;
                    end
                    default: begin
                        accel      <= accel_n;
                        steer      <= steer_n;
                        jerk       <= jerk_n;
                        prev_accel <= accel_n;
                        feat_valid <= 1'b1;
                        warm       <= 1'b1;
                        state      <= RUN;
                    end
                endcase
            end else begin
                if (idle_cnt < TO_CNT)
                    idle_cnt <= idle_cnt + 16'd1;
                // Fires once as the counter steps onto TIMEOUT; it then parks there.
                if (idle_cnt == TO_LAST) begin
                    state      <= EMPTY;
                    warm       <= 1'b0;
                    stale      <= 1'b1;
                    prev_speed <= '0;
                    prev_steer <= '0;
                    prev_accel <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ml_feature_extract.sv
module tb_ml_feature_extract;

    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_valid;
    logic        [7:0]  speed;
    logic signed [7:0]  steer_angle;
    logic        [7:0]  brake_in;
    logic signed [7:0]  accel;
    logic signed [7:0]  jerk;
    logic signed [7:0]  steer;
    logic        [7:0]  brake;
    logic               feat_valid;
    logic               warm;
    logic               stale;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] j;
        logic [7:0] s;
        logic [7:0] b;
        logic       fv;
        logic       w;
        logic       st;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int         m_state;
    int         m_idle;
    int         m_ps, m_pst, m_pa;
    logic [7:0] m_a, m_j, m_s, m_b;
    logic       m_fv, m_w, m_st;

    ml_feature_extract #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .speed(speed),
        .steer_angle(steer_angle), .brake_in(brake_in), .accel(accel), .jerk(jerk),
        .steer(steer), .brake(brake), .feat_valid(feat_valid), .warm(warm), .stale(stale)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int d);
        if (d > 127) return 127;
        if (d < -128) return -128;
        return d;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idle = 0; m_ps = 0; m_pst = 0; m_pa = 0;
        m_a = 0; m_j = 0; m_s = 0; m_b = 0; m_fv = 0; m_w = 0; m_st = 0;
    endtask

    // Called at a falling edge: drives one cycle of stimulus, predicts the
    // outputs after the next rising edge, then compares at the following fall.
    task automatic cycle(input logic v, input int sp, input int st, input int br);
        exp_t e;
        exp_t got;
        int   a;
        sample_valid = v;
        speed        = 8'(sp);
        steer_angle  = 8'(st);
        brake_in     = 8'(br);
        m_fv = 1'b0;
        if (v) begin
            m_st = 1'b0;
            m_idle = 0;
            m_b = 8'(br);
            if (m_state == 1) begin
                a = sat(sp - m_ps);
                m_a = 8'(a);
                m_s = 8'(sat(st - m_pst));
                m_j = 8'd0;
                m_pa = a;
                m_state = 2;
            end else if (m_state >= 2) begin
                a = sat(sp - m_ps);
                m_a = 8'(a);
                m_s = 8'(sat(st - m_pst));
                m_j = 8'(sat(a - m_pa));
                m_pa = a;
                m_fv = 1'b1;
                m_w = 1'b1;
                m_state = 3;
            end else begin
                m_state = 1;
            end
            m_ps = sp;
            m_pst = st;
        end else begin
            if (m_idle == TIMEOUT - 1) begin
                m_state = 0; m_w = 1'b0; m_st = 1'b1;
                m_ps = 0; m_pst = 0; m_pa = 0;
            end
            if (m_idle < TIMEOUT) m_idle++;
        end
        e = '{m_a, m_j, m_s, m_b, m_fv, m_w, m_st};
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        chk8("accel", accel, got.a);
        chk8("jerk", jerk, got.j);
        chk8("steer", steer, got.s);
        chk8("brake", brake, got.b);
        chk1("feat_valid", feat_valid, got.fv);
        chk1("warm", warm, got.w);
        chk1("stale", stale, got.st);
    endtask

    initial begin
        rst = 1'b0; sample_valid = 1'b0; speed = '0; steer_angle = '0; brake_in = '0;
        model_reset();
        #1;
        chk8("rst_accel", accel, 8'd0);
        chk8("rst_jerk", jerk, 8'd0);
        chk8("rst_steer", steer, 8'd0);
        chk8("rst_brake", brake, 8'd0);
        chk1("rst_fv", feat_valid, 1'b0);
        chk1("rst_warm", warm, 1'b0);
        chk1("rst_stale", stale, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // warm-up
        cycle(1, 10, 0, 3);
        chk1("wu1_fv", feat_valid, 1'b0);
        cycle(1, 20, 5, 4);
        chk8("wu2_accel", accel, 8'd10);
        chk8("wu2_steer", steer, 8'd5);
        chk8("wu2_jerk", jerk, 8'd0);
        chk1("wu2_fv", feat_valid, 1'b0);
        cycle(1, 35, 5, 7);
        chk8("wu3_accel", accel, 8'd15);
        chk8("wu3_jerk", jerk, 8'd5);
        chk8("wu3_steer", steer, 8'd0);
        chk1("wu3_fv", feat_valid, 1'b1);
        chk1("wu3_warm", warm, 1'b1);
        cycle(0, 0, 0, 0);
        chk1("wu_pulse_end", feat_valid, 1'b0);

        // saturation
        cycle(1, 0, 0, 1);
        cycle(1, 255, 127, 9);
        chk8("sat_accel_pos", accel, 8'h7F);
        cycle(1, 0, -128, 2);
        chk8("sat_accel_neg", accel, 8'h80);
        chk8("sat_jerk_neg", jerk, 8'h80);
        chk8("sat_steer_neg", steer, 8'h80);

        // back-to-back: two lead-in strobes, then five at +2 per sample
        cycle(1, 6, 0, 0);
        cycle(1, 8, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 10 + 2 * i, 0, i);
            chk1("b2b_fv", feat_valid, 1'b1);
            chk8("b2b_accel", accel, 8'd2);
            chk8("b2b_jerk", jerk, 8'd0);
        end

        // timeout
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0, 0);
        chk1("to_pre_stale", stale, 1'b0);
        cycle(0, 0, 0, 0);
        chk1("to_stale", stale, 1'b1);
        chk1("to_warm", warm, 1'b0);
        chk8("to_accel_held", accel, 8'd2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 50, 3, 5);
        chk1("to_prime_fv", feat_valid, 1'b0);
        chk1("to_prime_stale", stale, 1'b0);
        cycle(1, 60, 3, 5);
        chk1("to_s2_fv", feat_valid, 1'b0);
        cycle(1, 70, 3, 5);
        chk1("to_s3_fv", feat_valid, 1'b1);
        chk8("to_s3_accel", accel, 8'd10);

        // race: strobe on the edge the idle count would reach TIMEOUT
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0, 0);
        cycle(1, 80, 3, 6);
        chk1("race_stale", stale, 1'b0);
        chk1("race_fv", feat_valid, 1'b1);
        chk8("race_accel", accel, 8'd10);
        cycle(0, 0, 0, 0);

        // async reset between edges
        cycle(1, 90, 10, 8);
        sample_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk8("arst_accel", accel, 8'd0);
        chk8("arst_jerk", jerk, 8'd0);
        chk8("arst_steer", steer, 8'd0);
        chk8("arst_brake", brake, 8'd0);
        chk1("arst_fv", feat_valid, 1'b0);
        chk1("arst_warm", warm, 1'b0);
        chk1("arst_stale", stale, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cycle(1, 100, 0, 1);
        chk1("arst_prime_fv", feat_valid, 1'b0);
        cycle(1, 104, 0, 1);
        chk8("arst_s2_accel", accel, 8'd4);
        cycle(1, 108, 0, 1);
        chk1("arst_s3_fv", feat_valid, 1'b1);
        cycle(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
